fb_swap_ctrl: RTL and testbench
===============================

Name: fb_swap_ctrl

Overview:
- Double-buffer swap scheduler for the per-core framebuffers that the scan-out master reads.
- Each PPU core owns two banks. Scan-out reads the front bank while cores render into the back bank.
- This block starts each render pass, collects per-core completion, and swaps banks only on a scan-out frame boundary, so the display never shows a partially rendered frame.
- It sits in the GPU clock domain, between the core array and the scan-out reader.

Parameters:
- CORES_COUNT, 10, number of PPU cores; width of the done/start vectors.
- CNT_W, 16, width of the frame and dropped-frame counters.

Ports:
- clk  input  1  GPU clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  level; run swap cycles while high.
- frame_end  input  1  one-cycle pulse in the clk domain; scan-out has fetched the last pixel of a frame.
- core_done  input  CORES_COUNT  per-core one-cycle pulse; core i has finished writing its back bank.
- core_start  output  CORES_COUNT  one-cycle pulse, all bits together; cores begin rendering into the back bank.
- front_sel  output  1  bank index that scan-out reads; cores write bank ~front_sel.
- swap  output  1  one-cycle pulse in the cycle front_sel changes.
- busy  output  1  high in any state except IDLE.
- frame_count  output  CNT_W  number of completed swaps; wraps modulo 2^CNT_W.
- dropped_count  output  CNT_W  frame_end pulses with no new frame ready; saturates at all-ones.
- protocol_err  output  1  sticky; cleared only by rst.

Behaviour:
- Reset (rst high at a clk edge), all registered:
  - state = IDLE.
  - front_sel = 0, core_start = 0, swap = 0.
  - frame_count = 0, dropped_count = 0, protocol_err = 0.
  - done_mask = 0.
- Reset asserted mid-operation aborts everything; no start or swap pulse is emitted in the cycle after reset.
- States: IDLE, RENDER, WAIT_VSYNC, SWAP.
- IDLE:
  - If enable = 1, next cycle: state = RENDER, core_start = all ones for exactly one cycle, done_mask cleared.
  - frame_end pulses are ignored; dropped_count is not incremented.
- RENDER:
  - done_mask |= core_done each cycle.
  - all_done = &(done_mask | core_done). Same-cycle pulses count.
  - all_done with frame_end in the same cycle: go directly to SWAP.
  - all_done without frame_end: go to WAIT_VSYNC.
  - frame_end with !all_done: stay in RENDER; dropped_count += 1 (saturating).
- WAIT_VSYNC: on frame_end, go to SWAP. No other exit.
- SWAP, exactly one cycle:
  - swap = 1; front_sel toggled (the registered value changes on entry).
  - frame_count += 1; done_mask cleared.
  - Next state is RENDER with core_start pulse if enable = 1, else IDLE.
  - A frame_end arriving in this cycle increments dropped_count.
- Latency:
  - frame_end at edge t while in WAIT_VSYNC gives swap = 1 and the new front_sel at t+1.
  - core_start follows at t+2.
  - frame_end → swap latency is 1 cycle when all_done coincides with frame_end in RENDER.
- protocol_err is set on either of:
  - a core_done bit whose done_mask bit is already set (duplicate);
  - any core_done bit outside RENDER.
- Offending pulses are otherwise ignored.
- enable dropping mid-frame does not abort: the current pass completes, the swap happens, then the block goes to IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package gpu_pkg: enum fb_swap_state_t {IDLE, RENDER, WAIT_VSYNC, SWAP}, localparam FB_BANKS = 2.
- CORES_COUNT default lives in gpu_pkg.
- Sub-module sat_counter (parameter W; inc input; saturating count output) for dropped_count.
- frame_count is a plain wrapping counter in the top.

Test Plan:
- Reset, then enable = 1 with CORES_COUNT = 4 → core_start = 4'b1111 for exactly one cycle; busy = 1; front_sel = 0.
- All 4 cores pulse done at distinct cycles, then frame_end at cycle T → swap = 1 and front_sel = 1 at T+1; core_start at T+2; frame_count = 1.
- Only 3 of 4 cores done when 2 frame_ends arrive → dropped_count = 2, no swap. The 4th done plus the next frame_end → swap; frame_count = 1.
- Last core_done and frame_end in the same cycle → swap next cycle; dropped_count unchanged.
- Duplicate core_done[2] in RENDER → protocol_err = 1 and stays 1 until rst. core_done in IDLE also sets it.
- enable low during RENDER → pass completes, swap occurs, then busy = 0, no core_start. rst mid-RENDER → front_sel = 0, all counters 0, no pulses.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU-side definitions: framebuffer swap FSM states and core-array sizing.
package gpu_pkg;

  localparam int FB_BANKS       = 2;
  localparam int FB_CORES_COUNT = 10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RENDER     = 2'd1,
    WAIT_VSYNC = 2'd2,
    SWAP       = 2'd3
  } fb_swap_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap scheduler: starts render passes, gathers per-core done
// pulses and flips the scan-out bank only on a frame boundary.
import gpu_pkg::*;

// state      | meaning
// IDLE       | disabled, no pass in flight
// RENDER     | cores drawing into back bank, collecting done pulses
// WAIT_VSYNC | back bank complete, holding until scan-out frame_end
// SWAP       | one cycle: bank flipped, next pass launched if enabled
module fb_swap_ctrl #(
  parameter int CORES_COUNT = FB_CORES_COUNT,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   frame_end,
  input  logic [CORES_COUNT-1:0] core_done,
  output logic [CORES_COUNT-1:0] core_start,
  output logic                   front_sel,
  output logic                   swap,
  output logic                   busy,
  output logic [CNT_W-1:0]       frame_count,
  output logic [CNT_W-1:0]       dropped_count,
  output logic                   protocol_err
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_RENDER = RENDER;
  localparam logic [1:0] S_WAIT   = WAIT_VSYNC;
  localparam logic [1:0] S_SWAP   = SWAP;

  logic [1:0]             state, state_nxt;
  logic [CORES_COUNT-1:0] done_mask, done_mask_nxt;
  logic                   all_done;
  logic                   start_nxt;
  logic                   swap_nxt;
  logic                   drop_inc;
  logic                   err_nxt;

  // a done pulse arriving in the same cycle as the last missing bit still counts
  assign all_done = &(done_mask | core_done);

  always_comb begin
    state_nxt     = state;
    done_mask_nxt = done_mask;
    start_nxt     = 1'b0;
    swap_nxt      = 1'b0;
    drop_inc      = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt     = S_RENDER;
          start_nxt     = 1'b1;
          done_mask_nxt = '0;
        end
      end
      S_RENDER: begin
        done_mask_nxt = done_mask | core_done;
        if (all_done) begin
          if (frame_end) begin
            state_nxt = S_SWAP;
            swap_nxt  = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end else if (frame_end) begin
          drop_inc = 1'b1;
        end
      end
      S_WAIT: begin
        if (frame_end) begin
          state_nxt = S_SWAP;
          swap_nxt  = 1'b1;
        end
      end
      S_SWAP: begin
        drop_inc      = frame_end;
        done_mask_nxt = '0;
        if (enable) begin
          state_nxt = S_RENDER;
          start_nxt = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt     = S_IDLE;
        done_mask_nxt = '0;
      end
    endcase
    if (swap_nxt) begin
      done_mask_nxt = '0;
    end
  end

  // duplicate done inside a pass, or any done while no pass is collecting
  always_comb begin
    if (state == S_RENDER) begin
      err_nxt = |(core_done & done_mask);
    end else begin
      err_nxt = |core_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      done_mask    <= '0;
      core_start   <= '0;
      swap         <= 1'b0;
      front_sel    <= 1'b0;
      busy         <= 1'b0;
      frame_count  <= '0;
      protocol_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_mask  <= done_mask_nxt;
      core_start <= {CORES_COUNT{start_nxt}};
      swap       <= swap_nxt;
      busy       <= (state_nxt != S_IDLE);
      if (swap_nxt) begin
        front_sel   <= ~front_sel;
        frame_count <= frame_count + CNT_W'(1);
      end
      if (err_nxt) begin
        protocol_err <= 1'b1;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_dropped_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (dropped_count)
  );

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: directed passes checked every cycle against a pass-level model.
module tb_fb_swap_ctrl;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           frame_end;
  logic [N-1:0]   core_done;
  logic [N-1:0]   core_start;
  logic           front_sel;
  logic           swap;
  logic           busy;
  logic [W-1:0]   frame_count;
  logic [W-1:0]   dropped_count;
  logic           protocol_err;

  int checks = 0;
  int errors = 0;

  fb_swap_ctrl #(
    .CORES_COUNT (N),
    .CNT_W       (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .frame_end     (frame_end),
    .core_done     (core_done),
    .core_start    (core_start),
    .front_sel     (front_sel),
    .swap          (swap),
    .busy          (busy),
    .frame_count   (frame_count),
    .dropped_count (dropped_count),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  // pass-level model: idle / collecting / frame ready / just swapped
  bit m_valid = 0;
  bit m_idle, m_ready, m_in_swap;
  bit m_seen [N];
  int m_seen_cnt;
  bit m_start, m_swap, m_front, m_err;
  int m_fc, m_drop;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    bit go_swap;
    bit begin_pass;
    go_swap    = 0;
    begin_pass = 0;
    if (rst) begin
      m_valid = 1; m_idle = 1; m_ready = 0; m_in_swap = 0;
      m_start = 0; m_swap = 0; m_front = 0; m_err = 0;
      m_fc = 0; m_drop = 0; m_seen_cnt = 0;
      for (int i = 0; i < N; i++) m_seen[i] = 0;
    end else if (m_valid) begin
      m_start = 0;
      m_swap  = 0;
      if (m_in_swap) begin
        if (frame_end && m_drop < MAXV) m_drop++;
        if (|core_done) m_err = 1;
        m_in_swap = 0;
        if (enable) begin_pass = 1;
        else m_idle = 1;
      end else if (m_idle) begin
        if (|core_done) m_err = 1;
        if (enable) begin_pass = 1;
      end else if (m_ready) begin
        if (|core_done) m_err = 1;
        if (frame_end) go_swap = 1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (core_done[i]) begin
            if (m_seen[i]) m_err = 1;
            else begin m_seen[i] = 1; m_seen_cnt++; end
          end
        end
        if (m_seen_cnt == N) begin
          if (frame_end) go_swap = 1;
          else m_ready = 1;
        end else if (frame_end && m_drop < MAXV) begin
          m_drop++;
        end
      end
      if (begin_pass) begin
        m_idle  = 0;
        m_start = 1;
        m_seen_cnt = 0;
        for (int i = 0; i < N; i++) m_seen[i] = 0;
      end
      if (go_swap) begin
        m_swap    = 1;
        m_front   = ~m_front;
        m_fc      = (m_fc + 1) % (1 << W);
        m_in_swap = 1;
        m_ready   = 0;
        m_seen_cnt = 0;
        for (int i = 0; i < N; i++) m_seen[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("core_start",    32'(core_start),    m_start ? 32'(MAXV) : 32'd0);
      cmp("front_sel",     32'(front_sel),     32'(m_front));
      cmp("swap",          32'(swap),          32'(m_swap));
      cmp("busy",          32'(busy),          32'(!m_idle));
      cmp("frame_count",   32'(frame_count),   32'(m_fc));
      cmp("dropped_count", 32'(dropped_count), 32'(m_drop));
      cmp("protocol_err",  32'(protocol_err),  32'(m_err));
    end
  end

  task automatic cyc(input bit fe, input logic [N-1:0] cd);
    frame_end = fe;
    core_done = cd;
    @(negedge clk);
    frame_end = 0;
    core_done = '0;
  endtask

  initial begin
    rst = 1; enable = 0; frame_end = 0; core_done = '0;
    cyc(0, 4'h0);
    cyc(0, 4'h0);
    cmp("rst_front", 32'(front_sel), 0);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_fc", 32'(frame_count), 0);
    rst = 0;

    // first pass launch
    enable = 1;
    cyc(0, 4'h0);
    cmp("start_pulse", 32'(core_start), 32'hf);
    cmp("start_busy", 32'(busy), 1);
    cmp("start_front", 32'(front_sel), 0);
    cyc(0, 4'h0);
    cmp("start_one_cycle", 32'(core_start), 0);

    // distinct done cycles, then vsync
    cyc(0, 4'h1); cyc(0, 4'h2); cyc(0, 4'h4); cyc(0, 4'h8);
    cyc(0, 4'h0);
    cyc(1, 4'h0);
    cmp("swap_pulse", 32'(swap), 1);
    cmp("swap_front", 32'(front_sel), 1);
    cmp("swap_fc", 32'(frame_count), 1);
    cyc(0, 4'h0);
    cmp("restart_pulse", 32'(core_start), 32'hf);

    // frame_ends while incomplete are dropped
    cyc(0, 4'h1); cyc(1, 4'h2); cyc(0, 4'h4); cyc(1, 4'h0);
    cmp("drop_two", 32'(dropped_count), 2);
    cmp("drop_noswap", 32'(frame_count), 1);
    cyc(0, 4'h8);
    cyc(1, 4'h0);
    cmp("late_swap_fc", 32'(frame_count), 2);
    cyc(0, 4'h0);

    // last done coincides with frame_end; frame_end during SWAP counts as dropped
    cyc(0, 4'h1); cyc(0, 4'h2); cyc(0, 4'h4);
    cyc(1, 4'h8);
    cmp("coincide_swap", 32'(swap), 1);
    cmp("coincide_drop", 32'(dropped_count), 2);
    cyc(1, 4'h0);
    cmp("swapcycle_drop", 32'(dropped_count), 3);

    // duplicate done, then enable drop mid-pass
    cyc(0, 4'h4); cyc(0, 4'h4);
    cmp("dup_err", 32'(protocol_err), 1);
    cyc(0, 4'h1); cyc(0, 4'h2); cyc(0, 4'h8);
    enable = 0;
    cyc(1, 4'h0);
    cmp("disable_swap_fc", 32'(frame_count), 4);
    cyc(0, 4'h0);
    cmp("disable_idle", 32'(busy), 0);
    cmp("disable_nostart", 32'(core_start), 0);
    cyc(0, 4'h0);
    cmp("err_sticky", 32'(protocol_err), 1);

    // reset in the middle of a pass
    enable = 1;
    cyc(0, 4'h0);
    cyc(0, 4'h1); cyc(0, 4'h2); cyc(0, 4'h4); cyc(1, 4'h8);
    cyc(0, 4'h0);
    cyc(0, 4'h1);
    rst = 1;
    cyc(0, 4'h0);
    cmp("midrst_front", 32'(front_sel), 0);
    cmp("midrst_fc", 32'(frame_count), 0);
    cmp("midrst_drop", 32'(dropped_count), 0);
    cmp("midrst_err", 32'(protocol_err), 0);
    rst = 0; enable = 0;
    cyc(0, 4'h0);
    cmp("postrst_start", 32'(core_start), 0);
    cmp("postrst_swap", 32'(swap), 0);

    // idle ignores frame_end but flags core_done
    cyc(1, 4'h0);
    cmp("idle_nodrop", 32'(dropped_count), 0);
    cyc(0, 4'h2);
    cmp("idle_err", 32'(protocol_err), 1);
    rst = 1;
    cyc(0, 4'h0);
    rst = 0;

    // dropped_count saturation and frame_count wrap
    enable = 1;
    cyc(0, 4'h0);
    cyc(0, 4'h7);
    repeat (17) cyc(1, 4'h0);
    cmp("drop_sat", 32'(dropped_count), 15);
    cyc(1, 4'h8);
    cmp("wrap_first", 32'(frame_count), 1);
    cyc(0, 4'h0);
    for (int p = 0; p < 15; p++) begin
      cyc(0, 4'h7);
      cyc(1, 4'h8);
      cyc(0, 4'h0);
    end
    cmp("fc_wrap", 32'(frame_count), 0);
    cmp("drop_still_sat", 32'(dropped_count), 15);
    cmp("wrap_err_clear", 32'(protocol_err), 0);

    enable = 0;
    repeat (3) cyc(0, 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
